// File: rtl/ir_nec_encoder_pkg.sv
// NEC IR frame state encoding and per-state durations in protocol units.
package ir_nec_encoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD_MARK,
      ST_LEAD_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_TAIL_MARK,
      ST_GUARD
   } nec_state_e;

   localparam int unsigned LEAD_MARK_UNITS    = 16;
   localparam int unsigned LEAD_SPACE_UNITS   = 8;
   localparam int unsigned REPEAT_SPACE_UNITS = 4;
   localparam int unsigned MARK_UNITS         = 1;
   localparam int unsigned ZERO_SPACE_UNITS   = 1;
   localparam int unsigned ONE_SPACE_UNITS    = 3;

   function automatic logic is_mark(input nec_state_e s);
      return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_TAIL_MARK);
   endfunction

endpackage

// File: rtl/ir_nec_encoder_carrier_gen.sv
// Square-wave carrier, CARRIER_HALF cycles per half-period; restart forces high next cycle.
// Free-running while enabled, holds otherwise; no backpressure.
module ir_carrier_gen #(
   parameter int unsigned CARRIER_HALF = 658
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic carrier
);

   localparam int unsigned CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          carrier_q, carrier_d;

   always_comb begin
      cnt_d     = cnt_q;
      carrier_d = carrier_q;
      if (restart) begin
         cnt_d     = '0;
         carrier_d = 1'b1;
      end else if (enable) begin
         if (cnt_q == CW'(CARRIER_HALF - 1)) begin
            cnt_d     = '0;
            carrier_d = ~carrier_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         carrier_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         carrier_q <= carrier_d;
      end
   end

   assign carrier = carrier_q;

endmodule

// File: rtl/ir_nec_encoder.sv
// NEC IR transmitter: one frame per accepted request, first mark on the cycle after acceptance.
// oREADY only in IDLE, so iVALID during a frame is held off until the frame's guard time ends.
module ir_nec_encoder
   import ir_nec_encoder_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES  = 28125,
   parameter int unsigned CARRIER_HALF = 658,
   parameter int unsigned FRAME_BITS   = 32,
   parameter int unsigned LSB_FIRST    = 1,
   parameter int unsigned GUARD_UNITS  = 72
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic [FRAME_BITS-1:0] iDATA,
   input  logic                  iREPEAT,
   input  logic                  iVALID,
   output logic                  oREADY,
   output logic                  oIRDA_TXD,
   output logic                  oENVELOPE,
   output logic                  oBUSY,
   output logic                  oDONE
);

   localparam int unsigned MAX_UNITS = (GUARD_UNITS > LEAD_MARK_UNITS) ? GUARD_UNITS : LEAD_MARK_UNITS;
   localparam int unsigned CNT_W     = $clog2(MAX_UNITS * UNIT_CYCLES);
   localparam int unsigned BIT_W     = $clog2(FRAME_BITS + 1);

   nec_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic                  repeat_q, repeat_d;
   logic                  done_q, done_d;

   logic                  cur_bit;
   int unsigned           units;
   logic [CNT_W-1:0]      last_cnt;
   logic                  state_end;
   logic                  carrier;

   // The payload is shifted so the bit on air is always at one fixed end.
   always_comb begin
      cur_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[FRAME_BITS-1];
      case (state_q)
         ST_LEAD_MARK:  units = LEAD_MARK_UNITS;
         ST_LEAD_SPACE: units = repeat_q ? REPEAT_SPACE_UNITS : LEAD_SPACE_UNITS;
         ST_BIT_SPACE:  units = cur_bit ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
         ST_GUARD:      units = GUARD_UNITS;
         default:       units = MARK_UNITS;
      endcase
      last_cnt  = CNT_W'(units * UNIT_CYCLES - 1);
      state_end = (cnt_q == last_cnt);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = state_end ? '0 : cnt_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      repeat_d  = repeat_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (iVALID) begin
               state_d   = ST_LEAD_MARK;
               shift_d   = iDATA;
               repeat_d  = iREPEAT;
               bit_idx_d = '0;
            end
         end
         ST_LEAD_MARK:  if (state_end) state_d = ST_LEAD_SPACE;
         ST_LEAD_SPACE: if (state_end) state_d = repeat_q ? ST_TAIL_MARK : ST_BIT_MARK;
         ST_BIT_MARK:   if (state_end) state_d = ST_BIT_SPACE;
         ST_BIT_SPACE: begin
            if (state_end) begin
               shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
               if (bit_idx_q == BIT_W'(FRAME_BITS - 1)) begin
                  state_d = ST_TAIL_MARK;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
                  state_d   = ST_BIT_MARK;
               end
            end
         end
         ST_TAIL_MARK:  if (state_end) state_d = ST_GUARD;
         ST_GUARD: begin
            if (state_end) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default:       state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         repeat_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         repeat_q  <= repeat_d;
         done_q    <= done_d;
      end
   end

   // Every mark is entered from a non-mark state, so this restarts each mark high.
   ir_carrier_gen #(
      .CARRIER_HALF (CARRIER_HALF)
   ) u_carrier (
      .clk     (iCLK),
      .rst     (iRST),
      .enable  (is_mark(state_q)),
      .restart (!is_mark(state_q) && is_mark(state_d)),
      .carrier (carrier)
   );

   assign oENVELOPE = is_mark(state_q);
   assign oIRDA_TXD = oENVELOPE & carrier;
   assign oBUSY     = (state_q != ST_IDLE);
   assign oREADY    = (state_q == ST_IDLE);
   assign oDONE     = done_q;

endmodule

// File: tb/tb_ir_nec_encoder.sv
// Bench for ir_nec_encoder: LSB-first and MSB-first instances checked cycle by cycle
// against an envelope/carrier trace built from the NEC timing rules.
module tb_ir_nec_encoder;

   localparam int U    = 4;
   localparam int HALF = 1;
   localparam int G    = 2;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       rep;
   logic       v0, v1;
   logic       sel;

   logic rdy0, txd0, env0, busy0, done0;
   logic rdy1, txd1, env1, busy1, done1;
   logic ready, txd, env, busy, done;

   int checks = 0;
   int errors = 0;

   bit exp_env[$];
   bit exp_txd[$];

   ir_nec_encoder #(
      .UNIT_CYCLES(U), .CARRIER_HALF(HALF), .FRAME_BITS(8), .LSB_FIRST(1), .GUARD_UNITS(G)
   ) dut_lsb (
      .iCLK(clk), .iRST(rst), .iDATA(data), .iREPEAT(rep), .iVALID(v0), .oREADY(rdy0),
      .oIRDA_TXD(txd0), .oENVELOPE(env0), .oBUSY(busy0), .oDONE(done0)
   );

   ir_nec_encoder #(
      .UNIT_CYCLES(U), .CARRIER_HALF(HALF), .FRAME_BITS(8), .LSB_FIRST(0), .GUARD_UNITS(G)
   ) dut_msb (
      .iCLK(clk), .iRST(rst), .iDATA(data), .iREPEAT(rep), .iVALID(v1), .oREADY(rdy1),
      .oIRDA_TXD(txd1), .oENVELOPE(env1), .oBUSY(busy1), .oDONE(done1)
   );

   assign ready = sel ? rdy1  : rdy0;
   assign txd   = sel ? txd1  : txd0;
   assign env   = sel ? env1  : env0;
   assign busy  = sel ? busy1 : busy0;
   assign done  = sel ? done1 : done0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   function automatic void add_run(input bit lvl, input int n);
      for (int k = 0; k < n; k++) begin
         exp_env.push_back(lvl);
         exp_txd.push_back(lvl && (((k / HALF) % 2) == 0));
      end
   endfunction

   // Expected per-cycle trace, starting the cycle after acceptance, through the last guard cycle.
   function automatic void build_expect(input logic [7:0] d, input bit r, input bit lsb);
      exp_env.delete();
      exp_txd.delete();
      add_run(1'b1, 16 * U);
      add_run(1'b0, (r ? 4 : 8) * U);
      if (!r) begin
         for (int b = 0; b < 8; b++) begin
            bit v;
            v = ((d >> (lsb ? b : 7 - b)) & 8'd1) != 8'd0;
            add_run(1'b1, U);
            add_run(1'b0, (v ? 3 : 1) * U);
         end
      end
      add_run(1'b1, U);
      add_run(1'b0, G * U);
   endfunction

   task automatic set_valid(input bit s, input logic val);
      v0 = (s == 1'b0) ? val : 1'b0;
      v1 = s ? val : 1'b0;
   endtask

   // Entered at the falling edge of the first post-acceptance cycle; leaves at the done cycle.
   task automatic expect_frame(input string name);
      for (int i = 0; i < exp_env.size(); i++) begin
         chk($sformatf("%s env[%0d]", name, i), env, exp_env[i]);
         chk($sformatf("%s txd[%0d]", name, i), txd, exp_txd[i]);
         chk($sformatf("%s busy[%0d]", name, i), busy, 1'b1);
         chk($sformatf("%s ready[%0d]", name, i), ready, 1'b0);
         chk($sformatf("%s done[%0d]", name, i), done, 1'b0);
         @(negedge clk);
      end
      chk($sformatf("%s done_pulse", name), done, 1'b1);
      chk($sformatf("%s ready_at_done", name), ready, 1'b1);
      chk($sformatf("%s busy_at_done", name), busy, 1'b0);
      chk($sformatf("%s env_at_done", name), env, 1'b0);
   endtask

   task automatic present(input bit s, input logic [7:0] d, input bit r, input string name);
      @(negedge clk);
      sel  = s;
      data = d;
      rep  = r;
      set_valid(s, 1'b1);
      #1;
      chk($sformatf("%s ready_before", name), ready, 1'b1);
   endtask

   task automatic single_frame(input bit s, input logic [7:0] d, input bit r, input string name);
      build_expect(d, r, !s);
      present(s, d, r, name);
      @(negedge clk);
      set_valid(s, 1'b0);
      data = 8'($urandom);
      rep  = 1'($urandom);
      expect_frame(name);
      @(negedge clk);
      chk($sformatf("%s done_cleared", name), done, 1'b0);
      chk($sformatf("%s ready_idle", name), ready, 1'b1);
   endtask

   initial begin
      logic [7:0] d2;
      rst  = 1'b1;
      data = 8'h00;
      rep  = 1'b0;
      v0   = 1'b0;
      v1   = 1'b0;
      sel  = 1'b0;
      repeat (3) @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk($sformatf("reset%0d ready", s), ready, 1'b1);
         chk($sformatf("reset%0d busy", s), busy, 1'b0);
         chk($sformatf("reset%0d env", s), env, 1'b0);
         chk($sformatf("reset%0d txd", s), txd, 1'b0);
         chk($sformatf("reset%0d done", s), done, 1'b0);
      end
      rst = 1'b0;

      single_frame(1'b0, 8'hA5, 1'b0, "lsb_a5");
      single_frame(1'b1, 8'hA5, 1'b0, "msb_a5");
      single_frame(1'b1, 8'h01, 1'b0, "msb_01");
      single_frame(1'b0, 8'h01, 1'b0, "lsb_01");
      single_frame(1'b0, 8'($urandom), 1'b1, "repeat");

      // Back-to-back with iVALID held: the second frame's data is on the bus during the first.
      d2 = 8'($urandom);
      build_expect(8'h5A, 1'b0, 1'b1);
      present(1'b0, 8'h5A, 1'b0, "b2b1");
      @(negedge clk);
      data = d2;
      rep  = 1'b0;
      expect_frame("b2b1");
      build_expect(d2, 1'b0, 1'b1);
      @(negedge clk);
      v0   = 1'b0;
      data = 8'($urandom);
      expect_frame("b2b2");
      @(negedge clk);
      chk("b2b done_cleared", done, 1'b0);

      // Abort inside the first bit's space (bit 0 of A5 is a one: cycles 100..111).
      build_expect(8'hA5, 1'b0, 1'b1);
      present(1'b0, 8'hA5, 1'b0, "abort");
      @(negedge clk);
      v0 = 1'b0;
      repeat (101) @(negedge clk);
      chk("abort env_before", env, exp_env[101]);
      chk("abort busy_before", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort txd", txd, 1'b0);
      chk("abort env", env, 1'b0);
      chk("abort busy", busy, 1'b0);
      chk("abort ready", ready, 1'b1);
      chk("abort done", done, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("abort no_done[%0d]", k), done, 1'b0);
         chk($sformatf("abort idle_env[%0d]", k), env, 1'b0);
      end
      single_frame(1'b0, 8'hA5, 1'b0, "after_abort");

      // Reset wins over a simultaneous request.
      @(negedge clk);
      sel = 1'b0;
      rst = 1'b1;
      v0  = 1'b1;
      @(negedge clk);
      chk("rst_prio busy", busy, 1'b0);
      chk("rst_prio ready", ready, 1'b1);
      rst = 1'b0;
      v0  = 1'b0;
      @(negedge clk);
      chk("rst_prio still_idle", busy, 1'b0);
      chk("rst_prio env", env, 1'b0);

      for (int n = 0; n < 8; n++) begin
         single_frame(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                      $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
